led_blink_button_debounce: RTL

//  Conditions the raw push-button pin ahead of the button PIO in the led_blink system.

---
 rtl/led_blink_pkg.sv | 15 +
 rtl/led_blink_sync2.sv | 26 ++
 rtl/led_blink_button_debounce.sv | 125 ++++++++++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the led_blink button conditioning path.
package led_blink_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } btn_state_t;

  localparam int unsigned BTN_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned BTN_CNT_W_DEFAULT    = 16;
  localparam int unsigned BTN_PRESS_CNT_W      = 8;

endpackage

// File: rtl/led_blink_sync2.sv
// Generic two-flop synchroniser; synchronous active-high reset to 0.
module led_blink_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/led_blink_button_debounce.sv
// Push-button synchroniser + debouncer with press/release pulses.
// Define BTN_DEBOUNCE_PRESS_COUNT_EN to add the 8-bit press_count output.
module led_blink_button_debounce
  import led_blink_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = BTN_CNT_W_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_press,
`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
  output logic       btn_release,
  output logic [BTN_PRESS_CNT_W-1:0] press_count
`else
  output logic       btn_release
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       pressed_raw;
  logic       s2;
  btn_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic       level_q;
  logic       press_q;
  logic       release_q;

  // Normalise polarity so 1 always means pressed before synchronising.
  assign pressed_raw = btn_raw ^ ACTIVE_LOW;

  led_blink_sync2 #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pressed_raw),
    .q_o   (s2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (s2) begin
            state_q <= CHK_PRESS;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!s2) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state_q <= CHK_RELEASE;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_RELEASE: begin
          // Any pressed sample restarts the window: no partial credit.
          if (s2) begin
            state_q   <= PRESSED;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_DEBOUNCE_PRESS_COUNT_EN
  logic [BTN_PRESS_CNT_W-1:0] press_cnt_q;

  // Counts accepted presses, wrapping naturally at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_cnt_q <= '0;
    end else if (press_q) begin
      press_cnt_q <= press_cnt_q + BTN_PRESS_CNT_W'(1);
    end
  end

  assign press_count = press_cnt_q;
`endif

endmodule
